// File: rtl/tpu_pkg.sv
// Shared types for the TPU datapath.
//   extended_byte_type : 9-bit operand fed to the MAC array (byte plus extension bit)
//   extend_byte()      : sign- or zero-extends one input byte to extended_byte_type
package tpu_pkg;

  localparam int unsigned BYTE_WIDTH          = 8;
  localparam int unsigned EXTENDED_BYTE_WIDTH = 9;

  typedef logic [EXTENDED_BYTE_WIDTH-1:0] extended_byte_type;

  function automatic extended_byte_type extend_byte(input logic [BYTE_WIDTH-1:0] value,
                                                    input logic                  is_signed);
    return {is_signed & value[BYTE_WIDTH-1], value};
  endfunction

endpackage

// File: rtl/skew_shift_row.sv
// One row of the diagonal skew: a DEPTH-long chain of {valid, last, extended byte}
// registers. All stages advance together when enable is high and hold otherwise.
//   clk, rst            : clock, asynchronous active-low reset
//   enable              : advance the chain
//   shift_valid/last/data : value entering stage 0
//   row_valid/last/data : value in the final stage
//   any_valid           : OR of every stage's valid bit
module skew_shift_row
  import tpu_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              shift_valid,
  input  logic              shift_last,
  input  extended_byte_type shift_data,
  output logic              row_valid,
  output logic              row_last,
  output extended_byte_type row_data,
  output logic              any_valid
);

  logic              [DEPTH-1:0] valid_q;
  logic              [DEPTH-1:0] last_q;
  extended_byte_type [DEPTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else if (enable) begin
      valid_q[0] <= shift_valid;
      last_q[0]  <= shift_last;
      data_q[0]  <= shift_data;
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        last_q[s]  <= last_q[s-1];
        data_q[s]  <= data_q[s-1];
      end
    end
  end

  assign row_valid = valid_q[DEPTH-1];
  assign row_last  = last_q[DEPTH-1];
  assign row_data  = data_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/systolic_data_setup.sv
// Upstream feeder for the MAC array. Extends each input byte to 9 bits and skews the
// vector diagonally so row i reaches the array i cycles after row 0.
//   clk, rst        : clock, asynchronous active-low reset
//   enable          : global advance; 0 freezes every register
//   data_in         : MATRIX_WIDTH bytes, byte i at [8i+7:8i]
//   data_signed     : sign-extend (1) or zero-extend (0) this vector
//   in_valid        : data_in carries a real vector
//   in_last         : last vector of a batch (qualified by in_valid)
//   systolic_data   : skewed extended bytes, zero when the row's valid is low
//   systolic_valid  : per-row valid, aligned with systolic_data
//   last_out        : row MATRIX_WIDTH-1 is presenting the tagged last vector
//   busy            : any valid entry still inside the skew pipeline
module systolic_data_setup
  import tpu_pkg::*;
#(
  parameter int unsigned MATRIX_WIDTH = 14
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]  data_in,
  input  logic                                data_signed,
  input  logic                                in_valid,
  input  logic                                in_last,
  output extended_byte_type [MATRIX_WIDTH-1:0] systolic_data,
  output logic [MATRIX_WIDTH-1:0]             systolic_valid,
  output logic                                last_out,
  output logic                                busy
);

  logic                                 tagged_last;
  logic              [MATRIX_WIDTH-1:0] row_last;
  logic              [MATRIX_WIDTH-1:0] row_any_valid;
  extended_byte_type [MATRIX_WIDTH-1:0] row_data;
  logic              [MATRIX_WIDTH-1:0] unused_row_last;

  // in_last means nothing without in_valid.
  assign tagged_last = in_valid & in_last;

  for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_row
    skew_shift_row #(
      .DEPTH(i + 1)
    ) u_row (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .shift_valid(in_valid),
      // Only the final row reports end-of-batch; other rows never carry the tag.
      .shift_last (i == MATRIX_WIDTH - 1 ? tagged_last : 1'b0),
      .shift_data (extend_byte(data_in[BYTE_WIDTH*i +: BYTE_WIDTH], data_signed)),
      .row_valid  (systolic_valid[i]),
      .row_last   (row_last[i]),
      .row_data   (row_data[i]),
      .any_valid  (row_any_valid[i])
    );

    // Bubbles still shift their data bits; hide them from the array.
    assign systolic_data[i] = systolic_valid[i] ? row_data[i] : '0;
  end

  assign last_out        = row_last[MATRIX_WIDTH-1];
  assign busy            = |row_any_valid;
  assign unused_row_last = row_last;

endmodule

// File: tb/tb_systolic_data_setup.sv
module tb_systolic_data_setup;
  import tpu_pkg::*;

  localparam int unsigned W = 4;

  logic                          clk;
  logic                          rst;
  logic                          enable;
  logic [W*8-1:0]                data_in;
  logic                          data_signed;
  logic                          in_valid;
  logic                          in_last;
  extended_byte_type [W-1:0]     systolic_data;
  logic [W-1:0]                  systolic_valid;
  logic                          last_out;
  logic                          busy;

  int n_cmp = 0;
  int n_err = 0;

  systolic_data_setup #(
    .MATRIX_WIDTH(W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .data_in       (data_in),
    .data_signed   (data_signed),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .systolic_data (systolic_data),
    .systolic_valid(systolic_valid),
    .last_out      (last_out),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of captured vectors, newest first. Row i shows the vector
  // captured i enabled edges ago; anything older than W edges has left the pipeline.
  typedef struct {
    logic        valid;
    logic        last;
    logic        sgn;
    logic [31:0] data;
  } entry_t;

  entry_t hist[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_ext(input logic [7:0] b, input logic sgn);
    int v;
    v = int'(b);
    if (sgn && v >= 128) v = v + 256;
    return 9'(v);
  endfunction

  task automatic check_all();
    logic [35:0] exp_d;
    logic [3:0]  exp_v;
    logic        exp_l;
    logic        exp_b;
    logic [35:0] got_d;
    exp_d = '0;
    exp_v = '0;
    exp_l = 1'b0;
    exp_b = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (i < hist.size() && hist[i].valid) begin
        exp_v[i] = 1'b1;
        exp_d[9*i +: 9] = model_ext(hist[i].data[8*i +: 8], hist[i].sgn);
        exp_b = 1'b1;
      end
    end
    if (hist.size() >= int'(W)) exp_l = hist[W-1].valid && hist[W-1].last;
    got_d = systolic_data;
    check_eq("data", 64'(got_d), 64'(exp_d));
    check_eq("valid", 64'(systolic_valid), 64'(exp_v));
    check_eq("last_out", 64'(last_out), 64'(exp_l));
    check_eq("busy", 64'(busy), 64'(exp_b));
  endtask

  // Called at a negedge: drive, take one rising edge, update model, check at next negedge.
  task automatic tick(input logic en, input logic v, input logic l, input logic s,
                      input logic [31:0] d);
    entry_t e;
    enable      = en;
    in_valid    = v;
    in_last     = l;
    data_signed = s;
    data_in     = d;
    @(posedge clk);
    if (rst && en) begin
      e.valid = v;
      e.last  = v & l;
      e.sgn   = s;
      e.data  = d;
      hist.push_front(e);
      if (hist.size() > int'(W)) void'(hist.pop_back());
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
  endtask

  // Asserts reset between edges and checks outputs clear before any clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    hist.delete();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    logic [8:0] frozen;
    rst         = 1'b0;
    enable      = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    data_signed = 1'b0;
    data_in     = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
    check_all();
    idle(1);
    check_eq("busy_idle", 64'(busy), 64'(0));

    // Single unsigned vector with in_last.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h04030201);
    check_eq("row0_T", 64'(systolic_data[0]), 64'(9'h001));
    check_eq("valid_T", 64'(systolic_valid), 64'(4'b0001));
    idle(2);
    check_eq("last_T2", 64'(last_out), 64'(0));
    idle(1);
    check_eq("row3_T3", 64'(systolic_data[3]), 64'(9'h004));
    check_eq("last_T3", 64'(last_out), 64'(1));
    idle(1);
    check_eq("busy_T4", 64'(busy), 64'(0));

    // Sign handling.
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h000000F0);
    check_eq("sgn_f0", 64'(systolic_data[0]), 64'(9'h1F0));
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h000000F0);
    check_eq("uns_f0", 64'(systolic_data[0]), 64'(9'h0F0));
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000007F);
    check_eq("sgn_7f", 64'(systolic_data[0]), 64'(9'h07F));
    idle(5);

    // Stall: capture at T, one more enabled edge, then three frozen cycles.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'hA4B3C2D1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    frozen = systolic_data[1];
    check_eq("stall_row1", 64'(frozen), 64'(9'h0C2));
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1, $urandom);
      check_eq("stall_hold", 64'(systolic_data[1]), 64'(9'h0C2));
    end
    idle(1);
    check_eq("stall_row3_early", 64'(systolic_valid[3]), 64'(0));
    idle(1);
    check_eq("stall_row3", 64'(systolic_data[3]), 64'(9'h0A4));
    check_eq("stall_last", 64'(last_out), 64'(1));
    idle(5);

    // Streaming with a bubble between v1 and v2.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h82828282);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h33333333);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h84848484);
    idle(6);

    // Reset with three vectors in flight.
    tick(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
    tick(1'b1, 1'b1, 1'b1, 1'b1, $urandom);
    tick(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
    async_reset();
    idle(5);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) < 2) async_reset();
      tick(($urandom_range(99) < 80), ($urandom_range(99) < 70), ($urandom_range(99) < 25),
           1'($urandom), $urandom);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_data_setup.md
Name: systolic_data_setup

Overview:
- Upstream feeder for the mac_unit array.
- Takes one MATRIX_WIDTH-byte input vector per cycle and sign- or zero-extends each byte to extended_byte_type.
- Skews the vector diagonally: row i reaches the MAC array i cycles after row 0, as systolic dataflow needs.
- Also produces per-row valid (drives MAC enable) and end-of-batch markers for the downstream accumulator control.

Parameters:
- MATRIX_WIDTH, 14, number of array rows / bytes per input vector.

Ports:
- clk  in  1  clock; all registers rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  global advance; 0 freezes every register in the block.
- data_in  in  MATRIX_WIDTH*8  input vector; byte i = bits [8i+7:8i].
- data_signed  in  1  1: sign-extend the bytes of this vector; 0: zero-extend.
- in_valid  in  1  data_in is a real vector this cycle.
- in_last  in  1  this vector is the last of a batch; qualified by in_valid.
- systolic_data  out  MATRIX_WIDTH x extended_byte_type  skewed extended bytes; element i feeds array row i.
- systolic_valid  out  MATRIX_WIDTH  per-row valid, aligned with systolic_data[i].
- last_out  out  1  one-cycle pulse when row MATRIX_WIDTH-1 of the in_last vector is presented.
- busy  out  1  any valid entry still inside the skew pipeline.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-batch):
  - all pipeline registers clear immediately.
  - systolic_data=0, systolic_valid=0, last_out=0, busy=0.
  - No partial vector survives reset.
- Capture: on a rising edge with enable=1, data_in, data_signed, in_valid and in_last enter stage 0 of every row.
- Extension (at capture):
  - ext[7:0] = byte.
  - ext[8] = data_signed & byte[7].
- Skew: row i has i+1 register stages. A vector captured at edge T presents row i at the outputs after edge T+i, with enable high throughout.
- Output timing: all outputs are registered; no combinational path from any input to any output.
- Stall: enable=0 holds all stages, including valid and last tags.
  - Outputs stay constant while enable=0.
  - Timing resumes exactly where it stopped, shifted by the stall length.
- Bubbles: in_valid=0 inserts a bubble.
  - Data bits still shift, but the valid tag is 0.
  - A bubble at row i has systolic_valid[i]=0 and systolic_data[i]=0. Output data is masked by valid.
- in_last when in_valid=0: ignored.
- last_out:
  - Travels with row MATRIX_WIDTH-1 only.
  - Asserts exactly when systolic_valid[MATRIX_WIDTH-1]=1 for the tagged vector.
  - Repeats during a stall, since it is a held register value.
- busy: OR of every stage's valid bit. Goes low the cycle after the last valid leaves row MATRIX_WIDTH-1.
- Back-to-back: one vector per enabled cycle, no dead cycles.
  - Row i carries vectors in input order.
  - No ready/backpressure; the producer honours enable.
- MATRIX_WIDTH=1: single stage, latency 1, last_out aligned with systolic_valid[0].

Decomposition:
- tpu_pkg: extended_byte_type (9-bit packed), BYTE_WIDTH=8, EXTENDED_BYTE_WIDTH=9.
- Sub-module skew_shift_row:
  - Parameterised DEPTH; a chain of {valid, last, extended byte} registers with enable and async active-low reset.
  - Instantiated MATRIX_WIDTH times in a generate loop, with DEPTH=i+1.
- The top level holds the extension logic, busy reduction and last_out selection.

Test Plan (bench uses MATRIX_WIDTH=4):
- Reset release → all outputs 0; one cycle later, with in_valid=0, all outputs are still 0 and busy=0.
- Single unsigned vector {0x01,0x02,0x03,0x04} captured at edge T, in_last=1 → systolic_data[i]=0x00(i+1) with valid[i]=1, only after edge T+i; last_out=1 only after T+3; busy low after T+4.
- Sign handling: byte 0xF0 with data_signed=1 → 0x1F0 on the row. The same byte with data_signed=0 → 0x0F0. Byte 0x7F signed → 0x07F.
- Stall: capture a vector at T, drop enable for 3 cycles after T+1 → row 1 output frozen through the stall; row 3 appears after T+6 instead of T+3.
- Streaming: 4 back-to-back vectors v0..v3 with in_last on v3 → row 3 emits v0..v3 on consecutive cycles; last_out pulses only with v3; a bubble between v1 and v2 gives exactly one valid=0 cycle on each row.
- Asynchronous reset mid-stream: rst low between edges while 3 vectors are in flight → outputs 0 immediately, before the next edge; after release, no stale valid or last_out appears.
